// File: rtl/mips_muldiv_pkg.sv
// Shared types, constants and sign helpers for the HI/LO multiply/divide unit.
package mips_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  function automatic logic is_signed_op(input logic [2:0] o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  // Magnitude of a two's-complement word; 32'h80000000 maps to 2^31 unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sign_en);
    return (sign_en && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] neg_if32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  function automatic logic [63:0] neg_if64(input logic [63:0] v, input logic neg);
    return neg ? (64'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mips_divider_core.sv
// Unsigned 32/32 restoring divider, one quotient bit per step; load seeds the operands.
module mips_divider_core #(
  parameter int ITER_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder,
  output logic        o_last
);

  localparam int CNT_W = $clog2(ITER_CYCLES);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_CYCLES - 1);

  logic [31:0]      r_rem;
  logic [31:0]      r_quot;
  logic [31:0]      r_divisor;
  logic [CNT_W-1:0] r_count;

  logic [32:0] w_partial;
  logic [32:0] w_diff;
  logic        w_fits;

  // The partial remainder is below 2*divisor, so bit 32 of the difference is a clean borrow.
  assign w_partial = {r_rem, r_quot[31]};
  assign w_diff    = w_partial - {1'b0, r_divisor};
  assign w_fits    = ~w_diff[32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem     <= 32'd0;
      r_quot    <= 32'd0;
      r_divisor <= 32'd0;
      r_count   <= '0;
    end else if (i_load) begin
      r_rem     <= 32'd0;
      r_quot    <= i_dividend;
      r_divisor <= i_divisor;
      r_count   <= '0;
    end else if (i_step) begin
      r_rem   <= w_fits ? w_diff[31:0] : w_partial[31:0];
      r_quot  <= {r_quot[30:0], w_fits};
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_quotient  = r_quot;
  assign o_remainder = r_rem;
  assign o_last      = i_step & (r_count == LAST_ITER);

endmodule

// File: rtl/mips_muldiv_unit.sv
// HI/LO multiply/divide unit: iterative MULT/DIV with sign fix-up, plus MTHI/MTLO.
// Define MULDIV_FAST_MULT_EN to replace the shift-add multiplier with a one-cycle product.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int ITER_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(ITER_CYCLES);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_is_mul;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_b_zero;

  logic        w_accept;
  logic        w_is_mul_op;
  logic        w_is_div_op;
  logic        w_signed_op;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic        w_div_load;
  logic        w_div_step;
  logic        w_div_last;
  logic        w_mul_last;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [63:0] w_prod_mag;
  logic [63:0] w_prod;
  logic [31:0] w_hi_fix;
  logic [31:0] w_lo_fix;

  assign w_accept    = start & ~r_busy;
  assign w_is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign w_is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign w_signed_op = is_signed_op(op);
  assign w_a_abs     = abs32(operand_a, w_signed_op);
  assign w_b_abs     = abs32(operand_b, w_signed_op);
  assign w_div_load  = w_accept & w_is_div_op;
  assign w_div_step  = (r_state == ST_DIV);

  mips_divider_core #(
    .ITER_CYCLES(ITER_CYCLES)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_div_load),
    .i_step     (w_div_step),
    .i_dividend (w_a_abs),
    .i_divisor  (w_b_abs),
    .o_quotient (w_quot),
    .o_remainder(w_rem),
    .o_last     (w_div_last)
  );

`ifdef MULDIV_FAST_MULT_EN
  localparam state_t MUL_ENTRY = ST_FIX;

  logic [31:0] r_ma;
  logic [31:0] r_mb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ma <= 32'd0;
      r_mb <= 32'd0;
    end else if (w_accept) begin
      r_ma <= w_a_abs;
      r_mb <= w_b_abs;
    end
  end

  assign w_prod_mag = {32'd0, r_ma} * {32'd0, r_mb};
  assign w_mul_last = 1'b1;
`else
  localparam state_t MUL_ENTRY = ST_MUL;

  logic [63:0]      r_acc;
  logic [63:0]      r_mcand;
  logic [31:0]      r_mplier;
  logic [CNT_W-1:0] r_mul_cnt;

  // Radix-2 shift-add on magnitudes: multiplicand walks left, multiplier bits walk right.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc     <= 64'd0;
      r_mcand   <= 64'd0;
      r_mplier  <= 32'd0;
      r_mul_cnt <= '0;
    end else if (w_accept) begin
      r_acc     <= 64'd0;
      r_mcand   <= {32'd0, w_a_abs};
      r_mplier  <= w_b_abs;
      r_mul_cnt <= '0;
    end else if (r_state == ST_MUL) begin
      r_acc     <= r_mplier[0] ? (r_acc + r_mcand) : r_acc;
      r_mcand   <= {r_mcand[62:0], 1'b0};
      r_mplier  <= {1'b0, r_mplier[31:1]};
      r_mul_cnt <= r_mul_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign w_prod_mag = r_acc;
  assign w_mul_last = (r_mul_cnt == LAST_ITER);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_mul_op) begin
          w_state_next = MUL_ENTRY;
        end else if (w_accept && w_is_div_op) begin
          w_state_next = ST_DIV;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_MUL:  w_state_next = w_mul_last ? ST_FIX : ST_MUL;
      ST_DIV:  w_state_next = w_div_last ? ST_FIX : ST_DIV;
      ST_FIX:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Sign decisions are made from the raw operands at accept; later input changes are irrelevant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_mul <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
    end else if (w_accept) begin
      r_is_mul <= w_is_mul_op;
      r_neg_q  <= w_signed_op & (operand_a[31] ^ operand_b[31]);
      r_neg_r  <= w_signed_op & operand_a[31];
      r_b_zero <= (operand_b == 32'd0);
    end
  end

  assign w_prod = neg_if64(w_prod_mag, r_neg_q);

  // Divide by zero leaves the dividend magnitude as remainder, which sign-corrects back to operand_a.
  always_comb begin
    w_hi_fix = w_prod[63:32];
    w_lo_fix = w_prod[31:0];
    if (r_is_mul) begin
      w_hi_fix = w_prod[63:32];
      w_lo_fix = w_prod[31:0];
    end else if (r_b_zero) begin
      w_hi_fix = neg_if32(w_rem, r_neg_r);
      w_lo_fix = DIV0_QUOTIENT;
    end else begin
      w_hi_fix = neg_if32(w_rem, r_neg_r);
      w_lo_fix = neg_if32(w_quot, r_neg_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_next != ST_IDLE);
      r_done <= (r_state == ST_FIX);
    end
  end

  // MTHI/MTLO can only be accepted while idle, so they never collide with a FIX write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (r_state == ST_FIX) begin
      r_hi <= w_hi_fix;
      r_lo <= w_lo_fix;
    end else if (w_accept && (op == OP_MTHI)) begin
      r_hi <= operand_a;
    end else if (w_accept && (op == OP_MTLO)) begin
      r_lo <= operand_a;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: vector table plus hand-written multi-cycle sequences.
module tb_mips_muldiv_unit;
  import mips_muldiv_pkg::*;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_muldiv_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a request on the falling edge, return 1ns after the accept edge with inputs scrambled.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    op        = 3'd1;
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 200 && done !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int n;
    int lat;
    lat = ((v.op == OP_MULT) || (v.op == OP_MULTU)) ? MUL_LAT : DIV_LAT;
    issue(v.op, v.a, v.b);
    check({name, "_busy_accept"}, {63'd0, busy}, 64'd1);
    wait_done(n);
    check({name, "_latency"}, 64'(n), 64'(lat));
    check({name, "_hi"}, {32'd0, hi}, {32'd0, v.exp_hi});
    check({name, "_lo"}, {32'd0, lo}, {32'd0, v.exp_lo});
    check({name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    check({name, "_done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    vec_t v;

    reset     = 1'b0;
    start     = 1'b0;
    op        = 3'd0;
    operand_a = 32'd0;
    operand_b = 32'd0;

    vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{OP_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[6]  = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[7]  = '{OP_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
    vecs[8]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[10] = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[11] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    check("mthi_hi", {32'd0, hi}, 64'hDEAD_BEEF);
    check("mthi_lo", {32'd0, lo}, 64'd0);
    check("mthi_busy", {63'd0, busy}, 64'd0);
    check("mthi_done", {63'd0, done}, 64'd0);

    issue(OP_MTLO, 32'h1234_5678, 32'd0);
    check("mtlo_lo", {32'd0, lo}, 64'h1234_5678);
    check("mtlo_hi", {32'd0, hi}, 64'hDEAD_BEEF);
    check("mtlo_busy", {63'd0, busy}, 64'd0);

    issue(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd7, 32'h0BAD_0BAD, 32'd3);
    @(posedge clk);
    #1;
    check("undef_busy", {63'd0, busy}, 64'd0);
    check("undef_done", {63'd0, done}, 64'd0);
    check("undef_hi", {32'd0, hi}, 64'hDEAD_BEEF);
    check("undef_lo", {32'd0, lo}, 64'h1234_5678);

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // MTLO pulsed on the 10th edge of a divide must be dropped.
    issue(OP_DIVU, 32'd1000, 32'd10);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start     = 1'b1;
    op        = OP_MTLO;
    operand_a = 32'hAAAA_AAAA;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("midmtlo_lo_held", {32'd0, lo}, {32'd0, vecs[11].exp_lo});
    check("midmtlo_busy", {63'd0, busy}, 64'd1);
    wait_done(n);
    check("midmtlo_latency", 64'(n), 64'd23);
    check("midmtlo_lo", {32'd0, lo}, 64'd100);
    check("midmtlo_hi", {32'd0, hi}, 64'd0);

    // start held through completion: ignored at E33, accepted at E34.
    issue(OP_DIVU, 32'd50, 32'd7);
    @(negedge clk);
    start     = 1'b1;
    op        = OP_MTHI;
    operand_a = 32'h5555_5555;
    wait_done(n);
    check("b2b_latency", 64'(n), 64'(DIV_LAT));
    check("b2b_hi_e33", {32'd0, hi}, 64'd1);
    check("b2b_lo_e33", {32'd0, lo}, 64'd7);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_hi_e34", {32'd0, hi}, 64'h5555_5555);
    check("b2b_busy_e34", {63'd0, busy}, 64'd0);
    check("b2b_done_e34", {63'd0, done}, 64'd0);

    // Asynchronous reset in the middle of a multiply, away from any clock edge.
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    repeat (14) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_hi", {32'd0, hi}, 64'd0);
    check("arst_lo", {32'd0, lo}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("arst_done_hold", {63'd0, done}, 64'd0);
    check("arst_hi_hold", {32'd0, hi}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    v = '{OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3};
    run_vec(v, "post_rst_divu");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
